pmonitor_i2c_pio: RTL
=====================

# pmonitor_i2c_pio

Parametrised Avalon-MM general-purpose I/O port for the power-monitor subsystem. It replaces the single-bit, write-only SCL/SDA output ports with one bank of up to 32 pins. Each pin has its own direction control, an input synchroniser, atomic set/clear writes and edge capture with a maskable interrupt. The block sits on the Nios II data master beside the other QSYS peripherals and drives the I2C bit-bang pins and the monitor alert lines.

## Interface
Parameters:
- WIDTH, 8, number of pins, 1..32
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
- EDGE_TYPE, 1, edge captured: 0 rising, 1 falling, 2 either

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; read latency 0 (combinational from address)
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe_port  out  WIDTH  per-pin output enable (1 = drive); the top level builds the tristate
- irq  out  1  level interrupt

## Operation
- A write occurs when chipselect=1 and write_n=0. Register map, by word address:
  - 0 DATA: read returns the synchronised inputs; write loads out_port.
  - 1 DIR: read/write; 1 = output.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured edges; writing 1 to a bit clears that bit.
  - 4 OUTSET: writing 1 sets the matching out_port bit; reads 0.
  - 5 OUTCLR: writing 1 clears the matching out_port bit; reads 0.
  - 6, 7: read 0; writes ignored.
- Bits at or above WIDTH are ignored on write and read as 0.
- Synchroniser: two flops per pin, sync1 then sync2. A further flop, prev, holds the previous sync2.
- Edge term: sync2&~prev for rising, ~sync2&prev for falling, their OR for either.
- EDGE_CAP bit sets on its edge term and holds until cleared by software.
- If a new edge and a write-1-clear hit the same bit in the same cycle, the set wins.
- Edge-qualify counter: a 2-bit counter counts from 0 to 3 after reset and then saturates.
  - Edge terms are ignored while the counter is below 3.
  - This stops pins that are already high at reset release from producing a spurious rising capture.
- irq = OR over bits of (EDGE_CAP & IRQ_MASK). It is driven from registers, so it has no combinational path from the bus.
- Reset values:
  - out_port = RESET_VALUE; oe_port = 0 (all inputs); IRQ_MASK = 0; EDGE_CAP = 0.
  - sync1, sync2 and prev = 0; counter = 0; irq = 0.
- Reset asserted mid-operation clears every state element immediately. out_port snaps to RESET_VALUE with no clock needed.

## Timing
- DATA/OUTSET/OUTCLR/DIR write at clock edge k: out_port and oe_port show the new value after edge k.
- Input change meeting setup at edge k:
  - sync2 changes at k+1, so a DATA read shows the new value from k+1.
  - EDGE_CAP bit sets at edge k+2.
  - irq rises after k+2 if the bit is masked in.
- Mask write at edge k with a capture bit already pending: irq rises after k.
- EDGE_CAP clear at edge k: irq falls after k, unless a new edge sets the bit at k.
- Pulses shorter than one clock period may be missed; this is acceptable.
- First edge eligible for capture: sync2/prev values present at the 4th clock edge after reset release.

## Configuration
- PMON_PIO_EDGE_IRQ_EN:
  - Defined: edge capture, IRQ_MASK and irq are implemented as described.
  - Undefined: EDGE_CAP, IRQ_MASK and the edge-qualify counter are removed; addresses 2 and 3 read 0 and ignore writes; irq is tied to 0. The DATA synchroniser remains.

## Test plan
- Reset with RESET_VALUE=8'hA5, in_port=8'hFF -> out_port=A5, oe_port=00, irq=0; EDGE_CAP reads 0 after 10 clocks (no spurious capture).
- Write DATA=0x3C, then OUTSET=0x81, then OUTCLR=0x0C -> out_port reads 3C, BD, B1 after each respective write; writing DIR=0xF0 -> oe_port=F0.
- EDGE_TYPE=1, IRQ_MASK=0x02, drive in_port[1] 1->0 at edge k -> EDGE_CAP=0x02 at k+2, irq=1; write EDGE_CAP=0x02 -> irq=0 the next cycle.
- Falling edge on bit 1 arranged to set in the same cycle as a write-1-clear of bit 1 -> EDGE_CAP bit 1 stays 1 and irq stays 1.
- WIDTH=3: write DATA=0xFFFFFFFF -> readback of out_port is 0x7; reads of addresses 4-7 return 0.
- Assert reset_n low mid-sequence with out_port=0x55 and EDGE_CAP=0x01 -> out_port=RESET_VALUE and irq=0 without a clock edge. Build without PMON_PIO_EDGE_IRQ_EN -> irq stays 0 under all input toggles.

Source files
------------

// File: rtl/pmonitor_i2c_pio.sv
// pmonitor_i2c_pio
//   Avalon-MM general-purpose I/O bank for the power-monitor subsystem.
//   It drives the I2C bit-bang pins and reads the monitor alert lines.
//   Each pin has:
//     - a direction bit;
//     - a two-flop input synchroniser;
//     - atomic set/clear writes on the output register;
//     - optional edge capture with a maskable level interrupt.
//
// Parameters
//   WIDTH       number of pins, 1..32
//   RESET_VALUE reset value of the output data register
//   EDGE_TYPE   0 rising, 1 falling, 2 either
//
// Ports
//   i_clk, i_reset_n            system clock, async active-low reset
//   i_address, i_chipselect,
//   i_write_n, i_writedata      Avalon-MM slave write side
//   o_readdata                  zero-latency read data (decoded from i_address)
//   i_in_port                   asynchronous pin inputs
//   o_out_port, o_oe_port       output data and per-pin drive enable (1 = drive)
//   o_irq                       level interrupt
//
// Word map
//   0 DATA      read: synchronised inputs; write: load output register
//   1 DIR       read/write; 1 = output
//   2 IRQ_MASK  read/write
//   3 EDGE_CAP  read: captured edges; write 1 to clear
//   4 OUTSET    write 1 to set output bits; reads 0
//   5 OUTCLR    write 1 to clear output bits; reads 0
//   6, 7        read 0; writes ignored
//
// Build option
//   PMON_PIO_EDGE_IRQ_EN
//     Defined:   edge capture, IRQ_MASK and o_irq are implemented.
//     Undefined: words 2/3 read 0 and ignore writes, and o_irq is tied low.

module pmonitor_i2c_pio #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [2:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_out_port,
  output logic [WIDTH-1:0] o_oe_port,
  output logic             o_irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_CAP    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_oe;
  logic [31:0]      w_rd;

  assign w_wr    = i_chipselect & ~i_write_n;
  assign w_wdata = i_writedata[WIDTH-1:0];
  // Upper write-data bits have no storage behind them.
  assign w_unused_wdata = ^i_writedata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_out   <= RESET_VALUE;
      r_oe    <= '0;
    end else begin
      r_sync1 <= i_in_port;
      r_sync2 <= r_sync1;
      if (w_wr) begin
        case (i_address)
          ADDR_DATA:   r_out <= w_wdata;
          ADDR_DIR:    r_oe  <= w_wdata;
          ADDR_OUTSET: r_out <= r_out | w_wdata;
          ADDR_OUTCLR: r_out <= r_out & ~w_wdata;
          default:     ;
        endcase
      end
    end
  end

  assign o_out_port = r_out;
  assign o_oe_port  = r_oe;

`ifdef PMON_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_qual_cnt;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             r_irq;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [WIDTH-1:0] w_cap_nxt;

  always_comb begin
    w_rise = r_sync2 & ~r_prev;
    w_fall = ~r_sync2 & r_prev;
    if (EDGE_TYPE == 0)      w_edge = w_rise;
    else if (EDGE_TYPE == 1) w_edge = w_fall;
    else                     w_edge = w_rise | w_fall;
    // The synchroniser fills from zero after reset; a pin already high would
    // look like a rising edge until the pipeline has settled.
    if (r_qual_cnt != 2'd3) w_edge = '0;
    w_clr      = (w_wr && i_address == ADDR_CAP)  ? w_wdata : '0;
    w_mask_nxt = (w_wr && i_address == ADDR_MASK) ? w_wdata : r_mask;
    // The new edge is OR-ed in after the clear, so it wins a same-cycle race.
    w_cap_nxt  = (r_cap & ~w_clr) | w_edge;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev     <= '0;
      r_qual_cnt <= 2'd0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      if (r_qual_cnt != 2'd3) r_qual_cnt <= r_qual_cnt + 2'd1;
      r_mask <= w_mask_nxt;
      r_cap  <= w_cap_nxt;
      // Computed from next-state values so mask writes and clears show on
      // o_irq right after their own edge, yet o_irq stays a flop output.
      r_irq  <= |(w_cap_nxt & w_mask_nxt);
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (i_address)
      ADDR_DATA: w_rd[WIDTH-1:0] = r_sync2;
      ADDR_DIR:  w_rd[WIDTH-1:0] = r_oe;
`ifdef PMON_PIO_EDGE_IRQ_EN
      ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
      ADDR_CAP:  w_rd[WIDTH-1:0] = r_cap;
`endif
      default:   ;
    endcase
  end

  assign o_readdata = w_rd;

endmodule
